expr_eval: RTL

//   Downstream consumer of the ASCII expression character stream checked by the

---
 rtl/expr_eval.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/expr_eval.sv
// Evaluator for single-digit expressions d([+*]d)* closed by TERM; '*' binds tighter than '+'.
// Optional macro EXPR_EVAL_OVF_EN adds the ovf output (sticky per-expression overflow flag).
module expr_eval #(
    parameter int unsigned W    = 16,
    parameter logic [7:0]  TERM = 8'd61
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         in_valid,
    input  logic [7:0]   in,
    output logic [W-1:0] res,
    output logic         res_valid,
`ifdef EXPR_EVAL_OVF_EN
    output logic         ovf,
`endif
    output logic         err
);

    localparam logic [7:0] CH_ADD = 8'd43;
    localparam logic [7:0] CH_MUL = 8'd42;
    localparam logic [7:0] CH_D0  = 8'd48;
    localparam logic [7:0] CH_D9  = 8'd57;
    localparam int unsigned DW = 4;
`ifdef EXPR_EVAL_OVF_EN
    localparam int unsigned PW = W + DW;
    localparam int unsigned SW = W + 1;
`else
    localparam int unsigned PW = W;
    localparam int unsigned SW = W;
`endif

    typedef enum logic [1:0] {
        EXP_DIG = 2'd0,
        EXP_OP  = 2'd1,
        ERR     = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic [W-1:0]  sum, sum_nxt;
    logic [W-1:0]  prod, prod_nxt;
    logic [W-1:0]  res_nxt;
    logic          err_nxt;
    logic          res_valid_nxt;
    logic          emit_ok;
    logic          emit_err;

    logic          is_dig, is_add, is_mul, is_term;
    logic [DW-1:0] dig_val;
    logic [PW-1:0] prod_full;
    logic [SW-1:0] sum_full;

`ifdef EXPR_EVAL_OVF_EN
    logic          flag, flag_nxt;
    logic          ovf_nxt;
`endif

    // Character classification and datapath; upper bits exist only to feed the overflow flag.
    always_comb begin
        is_dig    = (in >= CH_D0) && (in <= CH_D9);
        is_add    = (in == CH_ADD);
        is_mul    = (in == CH_MUL);
        is_term   = (in == TERM);
        dig_val   = DW'(in - CH_D0);
        prod_full = PW'(prod) * PW'(dig_val);
        sum_full  = SW'(sum) + SW'(prod);
    end

    // Next-state, accumulator and result logic.
    always_comb begin
        state_nxt     = state;
        sum_nxt       = sum;
        prod_nxt      = prod;
        res_nxt       = res;
        err_nxt       = err;
        res_valid_nxt = 1'b0;
        emit_ok       = 1'b0;
        emit_err      = 1'b0;
`ifdef EXPR_EVAL_OVF_EN
        flag_nxt      = flag;
        ovf_nxt       = ovf;
`endif
        if (in_valid) begin
            unique case (state)
                EXP_DIG: begin
                    if (is_term) begin
                        emit_err = 1'b1;
                    end else if (is_dig) begin
                        prod_nxt  = prod_full[W-1:0];
                        state_nxt = EXP_OP;
`ifdef EXPR_EVAL_OVF_EN
                        flag_nxt  = flag | (|prod_full[PW-1:W]);
`endif
                    end else begin
                        state_nxt = ERR;
                    end
                end
                EXP_OP: begin
                    if (is_term) begin
                        emit_ok = 1'b1;
                    end else if (is_add) begin
                        sum_nxt   = sum_full[W-1:0];
                        prod_nxt  = W'(1);
                        state_nxt = EXP_DIG;
`ifdef EXPR_EVAL_OVF_EN
                        flag_nxt  = flag | sum_full[W];
`endif
                    end else if (is_mul) begin
                        state_nxt = EXP_DIG;
                    end else begin
                        state_nxt = ERR;
                    end
                end
                default: begin
                    if (is_term) begin
                        emit_err = 1'b1;
                    end
                end
            endcase
        end

        // Any emit closes the expression and rearms for the next one.
        if (emit_ok || emit_err) begin
            res_valid_nxt = 1'b1;
            sum_nxt       = '0;
            prod_nxt      = W'(1);
            state_nxt     = EXP_DIG;
            res_nxt       = emit_ok ? sum_full[W-1:0] : '0;
            err_nxt       = emit_err;
`ifdef EXPR_EVAL_OVF_EN
            flag_nxt      = 1'b0;
            ovf_nxt       = emit_ok & (flag | sum_full[W]);
`endif
        end
    end

    // State register and registered outputs.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state     <= EXP_DIG;
            sum       <= '0;
            prod      <= W'(1);
            res       <= '0;
            err       <= 1'b0;
            res_valid <= 1'b0;
`ifdef EXPR_EVAL_OVF_EN
            flag      <= 1'b0;
            ovf       <= 1'b0;
`endif
        end else begin
            state     <= state_nxt;
            sum       <= sum_nxt;
            prod      <= prod_nxt;
            res       <= res_nxt;
            err       <= err_nxt;
            res_valid <= res_valid_nxt;
`ifdef EXPR_EVAL_OVF_EN
            flag      <= flag_nxt;
            ovf       <= ovf_nxt;
`endif
        end
    end

endmodule
